ahblite_bus_arbiter: RTL and testbench
======================================

# ahblite_bus_arbiter

Two-master AHB-Lite arbiter that decides which master drives the shared system bus: the Cortex-M0 core (master 0) or the DMA engine (master 1). It sits between both masters and the master multiplexer. It drives the address-phase select that feeds `HMASTERSEL`, a registered data-phase select for `HWDATA`/`HRDATA` routing, and per-master `HREADY` gating. The select is no longer a static register bit owned by the DMA controller. Ownership changes only at safe points: the owning master's address phase is IDLE and the bus is ready. An optional fairness counter prevents DMA streams from starving the core.

## Interface
- `MAX_DMA_BEATS`, 16: DMA transfers accepted before the DMA is asked to yield to a waiting core (1..2^CNT_W-1).
- `CNT_W`, 5: beat counter width.
- `clk` in 1: system clock.
- `RSTn` in 1: reset, asynchronous, active-low.
- `core_req` in 1: core `HTRANSC[1]` (NONSEQ/SEQ pending).
- `dma_req` in 1: DMA `HTRANSD[1]`.
- `hready` in 1: muxed bus `HREADYOUT` from the slave mux.
- `addr_owner` out 1: address-phase owner, 0=core, 1=DMA; drives `HMASTERSEL`.
- `data_owner` out 1: data-phase owner; selects the `HWDATA` source and the `HRDATA` destination.
- `core_hready` out 1: `HREADYC` to the core.
- `dma_hready` out 1: `HREADYD` to the DMA.
- `dma_yield` out 1: request to the DMA to issue IDLE at its next address phase.
- `beat_cnt` out CNT_W: current DMA beat count (debug/visibility).

## Operation
- States:
  - `CORE_OWN` (reset, park state).
  - `DMA_OWN`.
  - `DMA_YIELD`: DMA owns the bus and `dma_yield`=1.
- `addr_owner` = 1 in `DMA_OWN` and `DMA_YIELD`; 0 in `CORE_OWN`.
- Release point: `hready`=1 and the owner's req=0, meaning the owner presents IDLE and the previous data phase completes at this edge.
- `CORE_OWN` -> `DMA_OWN`: at a release point with `dma_req`=1. The beat counter clears.
- `DMA_OWN` -> `CORE_OWN`: at a release point with `core_req`=1.
- `DMA_OWN` -> `DMA_YIELD`: when `beat_cnt` reaches `MAX_DMA_BEATS` and `core_req`=1.
- `DMA_YIELD` -> `CORE_OWN`: at a DMA release point. The core is granted regardless of `dma_req`.
- No other request: the current owner is kept (parking). Neither master is ever forced off mid-transfer.
- Beat counter: increments on each edge with `addr_owner`=1, `dma_req`=1 and `hready`=1. It saturates at `MAX_DMA_BEATS` and clears on entry to `DMA_OWN`.
- `data_owner` loads `addr_owner` on every edge with `hready`=1 and holds otherwise.
- `core_hready` = `hready` & (`addr_owner`==0 | `core_req`==0).
- `dma_hready` = `hready` & (`addr_owner`==1 | `dma_req`==0).
- A non-owner that is requesting is stalled with its address held. A non-owner that is IDLE sees normal `hready`.
- Simultaneous requests at a core release point: DMA wins (strict DMA priority); fairness is enforced only through `dma_yield`.

## Timing
- Reset values:
  - state `CORE_OWN`.
  - `addr_owner`=0, `data_owner`=0, `dma_yield`=0, `beat_cnt`=0.
  - `core_hready`=`hready`.
  - `dma_hready`=`hready` & ~`dma_req`.
- Handover latency: `addr_owner` changes on the clock edge that samples the release point. The new owner's held address is on the bus in the following cycle.
- `data_owner` follows `addr_owner` one `hready` edge later.
- `hready`=0: state, `data_owner` and `beat_cnt` all freeze.
- `dma_yield`: registered. It rises the cycle after the transition into `DMA_YIELD` and falls together with the switch to `CORE_OWN`.
- Reset mid-transfer: all state returns to reset values asynchronously; the core is parked.

## Configuration
- `ARB_FAIRNESS_EN` defined: beat counter, `DMA_YIELD` state and `dma_yield` are implemented as above.
- Without it:
  - `dma_yield` is tied to 0 and `beat_cnt` to 0.
  - `DMA_YIELD` is unreachable.
  - The DMA keeps the bus until it issues IDLE (strict priority).

## Test plan
- Reset and park: with `RSTn` low, then core only issuing 8 NONSEQ reads -> `addr_owner`=0, `data_owner`=0 throughout, `core_hready`=`hready`.
- Handover to DMA: `dma_req`=1 while the core streams, then the core issues IDLE with `hready`=1 -> `addr_owner`=1 the next cycle. `dma_hready` was 0 until then; `data_owner`=1 one ready edge later.
- Wait states: slave holds `hready`=0 for 3 cycles at a release point -> no switch until `hready`=1; `data_owner` is stable.
- Fairness: DMA streams 20 beats with `core_req`=1 from beat 1 -> `dma_yield`=1 after beat 16. DMA then IDLEs, `addr_owner`=0 the next cycle and `core_hready` goes high.
- Same stimulus without `ARB_FAIRNESS_EN` -> `dma_yield` stays 0; all 20 beats complete before the core is granted.
- Reset mid-DMA burst at beat 5 -> all outputs at reset values immediately, `addr_owner`=0.

Source files
------------

// File: rtl/ahblite_bus_arbiter.sv
// Two-master AHB-Lite arbiter (core = master 0, DMA = master 1) with safe-point handover.
// Optional DMA fairness counter / yield request enabled by defining ARB_FAIRNESS_EN.
module ahblite_bus_arbiter #(
  parameter int unsigned MAX_DMA_BEATS = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             core_req,
  input  logic             dma_req,
  input  logic             hready,
  output logic             addr_owner,
  output logic             data_owner,
  output logic             core_hready,
  output logic             dma_hready,
  output logic             dma_yield,
  output logic [CNT_W-1:0] beat_cnt
);

  if (MAX_DMA_BEATS < 1 || MAX_DMA_BEATS > (2 ** CNT_W) - 1) begin : g_bad_max_dma_beats
    $error("MAX_DMA_BEATS out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    CORE_OWN,
    DMA_OWN,
    DMA_YIELD
  } state_t;

  state_t state;
  logic   addr_owner_q;
  logic   data_owner_q;

`ifdef ARB_FAIRNESS_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DMA_BEATS);
  logic             dma_yield_q;
  logic [CNT_W-1:0] cnt_q;
`endif

  // Everything freezes while the slave inserts wait states.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state        <= CORE_OWN;
      addr_owner_q <= 1'b0;
      data_owner_q <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      dma_yield_q  <= 1'b0;
      cnt_q        <= '0;
`endif
    end else if (hready) begin
      data_owner_q <= addr_owner_q;
`ifdef ARB_FAIRNESS_EN
      if (state == CORE_OWN && !core_req && dma_req)
        cnt_q <= '0;
      else if (addr_owner_q && dma_req && cnt_q != MAX_CNT)
        cnt_q <= cnt_q + 1'b1;
`endif
      unique case (state)
        CORE_OWN: begin
          if (!core_req && dma_req) begin
            state        <= DMA_OWN;
            addr_owner_q <= 1'b1;
          end
        end
        DMA_OWN: begin
          if (!dma_req && core_req) begin
            state        <= CORE_OWN;
            addr_owner_q <= 1'b0;
          end
`ifdef ARB_FAIRNESS_EN
          else if (cnt_q == MAX_CNT && core_req) begin
            state       <= DMA_YIELD;
            dma_yield_q <= 1'b1;
          end
`endif
        end
        DMA_YIELD: begin
          // Core is granted at the DMA release point whether or not the DMA still wants the bus.
          if (!dma_req) begin
            state        <= CORE_OWN;
            addr_owner_q <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            dma_yield_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state        <= CORE_OWN;
          addr_owner_q <= 1'b0;
        end
      endcase
    end
  end

  assign addr_owner  = addr_owner_q;
  assign data_owner  = data_owner_q;
  assign core_hready = hready & (~addr_owner_q | ~core_req);
  assign dma_hready  = hready & (addr_owner_q | ~dma_req);

`ifdef ARB_FAIRNESS_EN
  assign dma_yield = dma_yield_q;
  assign beat_cnt  = cnt_q;
`else
  assign dma_yield = 1'b0;
  assign beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_ahblite_bus_arbiter.sv
// Directed bench for ahblite_bus_arbiter: ownership model checked every cycle plus literal spot checks.
module tb_ahblite_bus_arbiter;

`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       RSTn = 1'b0;
  logic       core_req = 1'b0;
  logic       dma_req = 1'b0;
  logic       hready = 1'b1;
  logic       addr_owner, data_owner, core_hready, dma_hready, dma_yield;
  logic [4:0] beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference model state
  bit m_owner = 1'b0;
  bit m_data  = 1'b0;
  bit m_yield = 1'b0;
  int m_cnt   = 0;

  ahblite_bus_arbiter #(.MAX_DMA_BEATS(MAXB), .CNT_W(5)) dut (
    .clk(clk), .RSTn(RSTn), .core_req(core_req), .dma_req(dma_req), .hready(hready),
    .addr_owner(addr_owner), .data_owner(data_owner), .core_hready(core_hready),
    .dma_hready(dma_hready), .dma_yield(dma_yield), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      m_owner = 1'b0; m_data = 1'b0; m_yield = 1'b0; m_cnt = 0;
    end else if (hready) begin
      bit o, y;
      int c;
      o = m_owner; y = m_yield; c = m_cnt;
      m_data = o;
      if (o && dma_req && c < MAXB) m_cnt = c + 1;
      if (!o) begin
        if (!core_req && dma_req) begin m_owner = 1'b1; m_cnt = 0; end
      end else if (y) begin
        if (!dma_req) begin m_owner = 1'b0; m_yield = 1'b0; end
      end else if (!dma_req && core_req) begin
        m_owner = 1'b0;
      end else if (FAIR && c == MAXB && core_req) begin
        m_yield = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("addr_owner", addr_owner, m_owner);
      check("data_owner", data_owner, m_data);
      check("core_hready", core_hready, hready & (!m_owner | !core_req));
      check("dma_hready", dma_hready, hready & (m_owner | !dma_req));
      check("dma_yield", dma_yield, FAIR ? m_yield : 0);
      check("beat_cnt", beat_cnt, FAIR ? m_cnt : 0);
    end
  end

  task automatic drive(input bit c, input bit d, input bit h);
    core_req = c; dma_req = d; hready = h;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1);
    #1 cmp_en = 1'b1;
    tick(2);
    check("rst_addr_owner", addr_owner, 0);
    check("rst_dma_hready", dma_hready, 0);
    check("rst_core_hready", core_hready, 1);
    RSTn = 1'b1;

    // Core streams 8 NONSEQ beats, DMA idle.
    drive(1'b1, 1'b0, 1'b1);
    tick(8);
    check("park_addr_owner", addr_owner, 0);
    check("park_core_hready", core_hready, 1);

    // DMA requests while core streams, then core goes IDLE.
    drive(1'b1, 1'b1, 1'b1);
    tick(3);
    check("ho_dma_stalled", dma_hready, 0);
    drive(1'b0, 1'b1, 1'b1);
    tick(1);
    check("ho_addr_owner", addr_owner, 1);
    check("ho_data_lag", data_owner, 0);
    tick(1);
    check("ho_data_owner", data_owner, 1);

    // Release point held off by 3 wait states.
    drive(1'b1, 1'b0, 1'b0);
    tick(3);
    check("ws_addr_hold", addr_owner, 1);
    check("ws_data_hold", data_owner, 1);
    hready = 1'b1;
    tick(1);
    check("ws_switch", addr_owner, 0);
    tick(1);
    check("ws_data_follow", data_owner, 0);

    // Fairness: DMA streams 20 beats with the core waiting.
    drive(1'b0, 1'b1, 1'b1);
    tick(1);
    check("fair_grant", addr_owner, 1);
    drive(1'b1, 1'b1, 1'b1);
    tick(20);
    check("fair_yield", dma_yield, FAIR ? 1 : 0);
    check("fair_cnt", beat_cnt, FAIR ? 16 : 0);
    check("fair_still_dma", addr_owner, 1);
    drive(1'b1, 1'b0, 1'b1);
    tick(1);
    check("fair_core_back", addr_owner, 0);
    check("fair_core_ready", core_hready, 1);
    check("fair_yield_drop", dma_yield, 0);

    // Reset in the middle of a DMA burst.
    drive(1'b0, 1'b1, 1'b1);
    tick(1);
    tick(5);
    check("mid_dma_owner", addr_owner, 1);
    RSTn = 1'b0;
    #1;
    check("mrst_addr_owner", addr_owner, 0);
    check("mrst_data_owner", data_owner, 0);
    check("mrst_yield", dma_yield, 0);
    check("mrst_cnt", beat_cnt, 0);
    check("mrst_dma_hready", dma_hready, 0);
    tick(2);
    RSTn = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    tick(3);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
